elevator_ctrl: RTL and testbench

Single-car elevator controller for an 8-floor building. It latches hall/car button presses, schedules the car with a direction-preference (SCAN-style) policy, and times floor-to-floor travel and door dwell from a 1 Hz tick. It sits directly upstream of the display stage and drives that stage's `floor`, `countdown`, `floor_btn` and `status` inputs.

---
 rtl/elevator_ctrl_if.sv | 11 +
 rtl/elevator_ctrl.sv | 90 +++++++++
 tb/tb_elevator_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/elevator_ctrl_if.sv
// elevator_ctrl_if: button/tick inputs and display-facing outputs of the elevator controller
interface elevator_ctrl_if;
  logic       tick;
  logic [7:0] btn;
  logic [3:0] floor;
  logic [3:0] countdown;
  logic [7:0] floor_btn;
  logic [3:0] status;
  modport master (output tick, btn, input floor, countdown, floor_btn, status);
  modport slave  (input tick, btn, output floor, countdown, floor_btn, status);
endinterface

// File: rtl/elevator_ctrl.sv
// elevator_ctrl: single-car 8-floor SCAN scheduler with tick-timed travel and door dwell
module elevator_ctrl #(
  parameter int TRAVEL_TICKS = 3,
  parameter int DOOR_TICKS   = 5
) (
  input logic ck,
  input logic rst_n,
  elevator_ctrl_if.slave bus
);
  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    MOVE_UP   = 4'b0010,
    MOVE_DOWN = 4'b0100,
    DOOR_OPEN = 4'b1000
  } state_t;
  localparam logic [3:0] TT = 4'(TRAVEL_TICKS);
  localparam logic [3:0] DT = 4'(DOOR_TICKS);
  state_t     state;
  logic [2:0] fl, nf;
  logic [3:0] cnt;
  logic [7:0] req, pend;
  logic       pref_up, go_up, go_down;
  function automatic logic above(input logic [2:0] f, input logic [7:0] r);
    return |(r & ~((8'd2 << f) - 8'd1));
  endfunction
  function automatic logic below(input logic [2:0] f, input logic [7:0] r);
    return |(r & ((8'd1 << f) - 8'd1));
  endfunction
  // a press of the floor whose door is already open is dropped
  always_comb begin
    pend    = req | (bus.btn & ~((state == DOOR_OPEN) ? (8'd1 << fl) : 8'd0));
    nf      = (state == MOVE_UP) ? fl + 3'd1 : fl - 3'd1;
    go_up   = above(fl, req) && (pref_up || !below(fl, req));
    go_down = below(fl, req) && (!pref_up || !above(fl, req));
  end
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      fl      <= 3'd0;
      cnt     <= 4'd0;
      req     <= 8'd0;
      pref_up <= 1'b1;
    end else begin
      req <= pend;
      case (state)
        IDLE: begin
          if (req[fl]) begin
            state <= DOOR_OPEN;
            cnt   <= DT;
            req   <= pend & ~(8'd1 << fl);
          end else if (go_up) begin
            state   <= MOVE_UP;
            cnt     <= TT;
            pref_up <= 1'b1;
          end else if (go_down) begin
            state   <= MOVE_DOWN;
            cnt     <= TT;
            pref_up <= 1'b0;
          end else
            cnt <= 4'd0;
        end
        MOVE_UP, MOVE_DOWN: if (bus.tick) begin
          if (cnt == 4'd1) begin
            fl <= nf;
            if (pend[nf]) begin
              state <= DOOR_OPEN;
              cnt   <= DT;
              req   <= pend & ~(8'd1 << nf);
            end else if ((state == MOVE_UP) ? above(nf, pend) : below(nf, pend))
              cnt <= TT;
            else begin
              state <= IDLE;
              cnt   <= 4'd0;
            end
          end else
            cnt <= cnt - 4'd1;
        end
        DOOR_OPEN: if (bus.tick) begin
          state <= (cnt == 4'd1) ? IDLE : DOOR_OPEN;
          cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign bus.floor     = {1'b0, fl};
  assign bus.countdown = cnt;
  assign bus.floor_btn = req;
  assign bus.status    = state;
endmodule

// File: tb/tb_elevator_ctrl.sv
// tb_elevator_ctrl: directed scenarios with hand-computed expectations (TRAVEL=3, DOOR=5)
module tb_elevator_ctrl;
  logic ck = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  elevator_ctrl_if bus();
  elevator_ctrl #(.TRAVEL_TICKS(3), .DOOR_TICKS(5)) dut (.ck(ck), .rst_n(rst_n), .bus(bus));
  always #5 ck = ~ck;
  task automatic cyc();
    @(posedge ck);
    #1;
  endtask
  task automatic ticks(input int n);
    repeat (n) begin
      bus.tick = 1'b1;
      cyc();
      bus.tick = 1'b0;
    end
  endtask
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic chk4(input string tag, input logic [3:0] f, input logic [3:0] c,
                      input logic [7:0] fb, input logic [3:0] st);
    chk({tag, ".floor"}, {4'd0, bus.floor}, {4'd0, f});
    chk({tag, ".countdown"}, {4'd0, bus.countdown}, {4'd0, c});
    chk({tag, ".floor_btn"}, bus.floor_btn, fb);
    chk({tag, ".status"}, {4'd0, bus.status}, {4'd0, st});
  endtask
  task automatic press(input logic [7:0] b);
    bus.btn = b;
    cyc();
    bus.btn = 8'd0;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    cyc();
  endtask
  initial begin
    rst_n   = 1'b0;
    bus.tick = 1'b0;
    bus.btn  = 8'd0;
    repeat (3) cyc();
    rst_n = 1'b1;
    cyc();
    chk4("reset", 4'd0, 4'd0, 8'h00, 4'b0001);
    press(8'h01);
    chk("p_latch.fb", bus.floor_btn, 8'h01);
    chk("p_latch.st", {4'd0, bus.status}, 8'h01);
    cyc();
    chk4("p_door", 4'd0, 4'd5, 8'h00, 4'b1000);
    ticks(4);
    chk4("p_door4", 4'd0, 4'd1, 8'h00, 4'b1000);
    ticks(1);
    chk4("p_close", 4'd0, 4'd0, 8'h00, 4'b0001);
    press(8'h08);
    chk("t_latch.fb", bus.floor_btn, 8'h08);
    bus.tick = 1'b1;
    cyc();
    bus.tick = 1'b0;
    chk4("t_exit", 4'd0, 4'd3, 8'h08, 4'b0010);
    ticks(2);
    chk4("t_cnt1", 4'd0, 4'd1, 8'h08, 4'b0010);
    ticks(1);
    chk4("t_floor1", 4'd1, 4'd3, 8'h08, 4'b0010);
    ticks(6);
    chk4("t_arrive", 4'd3, 4'd5, 8'h00, 4'b1000);
    ticks(5);
    chk4("t_close", 4'd3, 4'd0, 8'h00, 4'b0001);
    do_reset();
    chk4("rst2", 4'd0, 4'd0, 8'h00, 4'b0001);
    press(8'h20);
    cyc();
    chk4("i_exit", 4'd0, 4'd3, 8'h20, 4'b0010);
    ticks(3);
    chk4("i_floor1", 4'd1, 4'd3, 8'h20, 4'b0010);
    press(8'h04);
    chk("i_latch.fb", bus.floor_btn, 8'h24);
    ticks(3);
    chk4("i_stop", 4'd2, 4'd5, 8'h20, 4'b1000);
    press(8'h04);
    chk("door_drop.fb", bus.floor_btn, 8'h20);
    ticks(5);
    chk4("i_close", 4'd2, 4'd0, 8'h20, 4'b0001);
    cyc();
    chk4("i_resume", 4'd2, 4'd3, 8'h20, 4'b0010);
    ticks(9);
    chk4("i_arrive", 4'd5, 4'd5, 8'h00, 4'b1000);
    ticks(5);
    chk4("i_close5", 4'd5, 4'd0, 8'h00, 4'b0001);
    do_reset();
    chk4("rst3", 4'd0, 4'd0, 8'h00, 4'b0001);
    press(8'h08);
    cyc();
    ticks(9);
    chk4("d_at3", 4'd3, 4'd5, 8'h00, 4'b1000);
    press(8'h42);
    chk4("d_latch", 4'd3, 4'd5, 8'h42, 4'b1000);
    ticks(5);
    chk4("d_close", 4'd3, 4'd0, 8'h42, 4'b0001);
    cyc();
    chk4("d_up", 4'd3, 4'd3, 8'h42, 4'b0010);
    ticks(9);
    chk4("d_at6", 4'd6, 4'd5, 8'h02, 4'b1000);
    ticks(5);
    chk4("d_close6", 4'd6, 4'd0, 8'h02, 4'b0001);
    cyc();
    chk4("d_down", 4'd6, 4'd3, 8'h02, 4'b0100);
    ticks(6);
    chk4("d_at4", 4'd4, 4'd3, 8'h02, 4'b0100);
    rst_n = 1'b0;
    #2;
    chk4("async_rst", 4'd0, 4'd0, 8'h00, 4'b0001);
    cyc();
    rst_n = 1'b1;
    cyc();
    chk4("post_rst", 4'd0, 4'd0, 8'h00, 4'b0001);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
